// File: rtl/image_pkg.sv
// Shared image-pipeline definitions: BMP row geometry helpers, header size and
// the pixel packer state encoding.
package image_pkg;

    localparam int BMP_HEADER_SIZE = 54;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EMIT   = 2'd1,
        S_PAD    = 2'd2,
        S_ROWEND = 2'd3
    } packer_state_t;

    // Bytes in one stored BMP row, rounded up to a 4-byte boundary.
    function automatic int bmp_row_bytes(input int width, input int channels);
        return ((width * channels + 3) / 4) * 4;
    endfunction

    function automatic int bmp_pad_bytes(input int width, input int channels);
        return (4 - ((width * channels) % 4)) % 4;
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Column/row position tracker with wrap-around and last-column/last-row flags,
// shared by raster-order blocks such as the BMP packer and the sobel line buffer.
module pixel_pos_counter #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           col_adv,
    input  logic                           row_adv,
    output logic [$clog2(HEIGHT+1)-1:0]    row,
    output logic                           last_col,
    output logic                           last_row
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_adv) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
        if (row_adv) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign row      = row_q;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

endmodule

// File: rtl/bmp_pixel_packer.sv
// Expands one grayscale source word into CHANNELS identical bytes, appends BMP
// row padding and tracks frame position. Optional checksum: PACKER_CHECKSUM_EN.
module bmp_pixel_packer
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int IN_DWIDTH  = 8,
    parameter int CHANNELS   = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [IN_DWIDTH-1:0]               in_dout,
    input  logic                               in_empty,
    output logic                               in_rd_en,
    output logic [7:0]                         out_din,
    input  logic                               out_full,
    output logic                               out_wr_en,
    output logic                               busy,
    output logic                               frame_done,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]    row_count,
`ifdef PACKER_CHECKSUM_EN
    output logic [15:0]                        frame_sum,
`endif
    output packer_state_t                      state_dbg
);

    // Handshakes: a source word is consumed in a cycle where in_rd_en=1 and
    // in_empty=0; a byte is accepted in a cycle where out_wr_en=1 (only ever
    // raised while out_full=0). Both are decided from registered state.

    localparam int PAD_BYTES = bmp_pad_bytes(IMG_WIDTH, CHANNELS);
    localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PAD_W     = 2;
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);
    localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'((PAD_BYTES > 0) ? PAD_BYTES - 1 : 0);

    packer_state_t     state_q, state_d;
    logic [7:0]        pix_q, pix_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [PAD_W-1:0]  pad_q, pad_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic col_adv;
    logic row_adv;
    logic row_end_go;
    logic last_col;
    logic last_row;

    pixel_pos_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clock    (clock),
        .reset    (reset),
        .col_adv  (col_adv),
        .row_adv  (row_adv),
        .row      (row_count),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        chan_d     = chan_q;
        pad_d      = pad_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = 8'h00;
        col_adv    = 1'b0;
        row_adv    = 1'b0;
        row_end_go = 1'b0;

        case (state_q)
            S_FETCH: begin
                in_rd_en = ~in_empty;
                if (!in_empty) begin
                    pix_d   = in_dout[IN_DWIDTH-1 -: 8];
                    chan_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                out_din   = pix_q;
                out_wr_en = ~out_full;
                if (!out_full) begin
                    chan_d = chan_q + 1'b1;
                    if (chan_q == CHAN_LAST) begin
                        chan_d  = '0;
                        col_adv = 1'b1;
                        if (!last_col) begin
                            // Chain straight into the next pixel when one is waiting.
                            if (!in_empty) begin
                                in_rd_en = 1'b1;
                                pix_d    = in_dout[IN_DWIDTH-1 -: 8];
                            end else begin
                                state_d = S_FETCH;
                            end
                        end else if (PAD_BYTES > 0) begin
                            pad_d   = '0;
                            state_d = S_PAD;
                        end else begin
                            row_end_go = 1'b1;
                        end
                    end
                end
            end

            S_PAD: begin
                out_wr_en = ~out_full;
                if (!out_full) begin
                    pad_d = pad_q + 1'b1;
                    if (pad_q == PAD_LAST) begin
                        pad_d      = '0;
                        row_end_go = 1'b1;
                    end
                end
            end

            S_ROWEND: begin
                row_adv = 1'b1;
                state_d = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // frame_done/busy settle on entry to S_ROWEND so the pulse lands one
        // cycle after the final byte and the next frame may fetch right after.
        if (row_end_go) begin
            state_d = S_ROWEND;
            if (last_row) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pix_q   <= '0;
            chan_q  <= '0;
            pad_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            chan_q  <= chan_d;
            pad_q   <= pad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign state_dbg  = state_q;

`ifdef PACKER_CHECKSUM_EN
    logic [15:0] sum_acc_q, sum_acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    // The final byte of a frame is folded in before capture, then the
    // accumulator restarts for the next frame.
    always_comb begin
        sum_acc_d   = sum_acc_q;
        frame_sum_d = frame_sum_q;
        if (out_wr_en) begin
            sum_acc_d = sum_acc_q + {8'h00, out_din};
        end
        if (done_d) begin
            frame_sum_d = sum_acc_d;
            sum_acc_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_acc_q   <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_acc_q   <= sum_acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`endif

endmodule

// File: tb/tb_bmp_pixel_packer.sv
// Self-checking bench for bmp_pixel_packer on a 5x2x3 image: randomized source
// gaps and sink back-pressure checked against a raster-order byte model.
module tb_bmp_pixel_packer;
    import image_pkg::*;

    localparam int W   = 5;
    localparam int H   = 2;
    localparam int CH  = 3;
    localparam int DW  = 8;
    localparam int RCW = $clog2(H + 1);

    logic            clock = 1'b0;
    logic            reset;
    logic [DW-1:0]   in_dout;
    logic            in_empty;
    logic            in_rd_en;
    logic [7:0]      out_din;
    logic            out_full;
    logic            out_wr_en;
    logic            busy;
    logic            frame_done;
    logic [RCW-1:0]  row_count;
    packer_state_t   state_dbg;
`ifdef PACKER_CHECKSUM_EN
    logic [15:0]     frame_sum;
`endif

    bmp_pixel_packer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .IN_DWIDTH  (DW),
        .CHANNELS   (CH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_dout    (in_dout),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .out_din    (out_din),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .busy       (busy),
        .frame_done (frame_done),
        .row_count  (row_count),
`ifdef PACKER_CHECKSUM_EN
        .frame_sum  (frame_sum),
`endif
        .state_dbg  (state_dbg)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and stimulus state.
    logic [7:0]    exp_q[$];
    logic [DW-1:0] src_q[$];
    logic [15:0]   sum_q[$];
    int sink_full_pct = 0;
    int src_mode      = 0;   // 0: no gaps, 1: gap every other cycle, 2: random gaps
    int cyc = 0;
    int pops, writes, fd_count, last_wr_cyc, busy_err, wr_while_full, pop_while_empty;
    int rc_max;
    bit in_frame = 0;
    bit restart_pend = 0;

    // Expected raster byte stream for a frame: each pixel replicated per channel,
    // each row zero-extended to a multiple of four bytes.
    task automatic load_frame(input bit ramp);
        logic [7:0] v;
        logic [15:0] s;
        int row_len;
        s = '0;
        for (int r = 0; r < H; r++) begin
            row_len = 0;
            for (int c = 0; c < W; c++) begin
                v = ramp ? 8'(r * W + c + 1) : 8'($urandom_range(0, 255));
                src_q.push_back(v);
                for (int k = 0; k < CH; k++) begin
                    exp_q.push_back(v);
                    s = s + {8'h00, v};
                    row_len++;
                end
            end
            while (row_len % 4 != 0) begin
                exp_q.push_back(8'h00);
                row_len++;
            end
        end
        sum_q.push_back(s);
    endtask

    task automatic clear_counts();
        pops = 0; writes = 0; fd_count = 0; last_wr_cyc = 0; busy_err = 0;
        wr_while_full = 0; pop_while_empty = 0; rc_max = 0;
    endtask

    // One clock: drive at the falling edge, sample combinational handshakes 1ns later.
    task automatic step();
        bit gap;
        @(negedge clock);
        cyc++;
        case (src_mode)
            1:       gap = (cyc % 2 == 1);
            2:       gap = ($urandom_range(0, 99) < 30);
            default: gap = 1'b0;
        endcase
        in_empty = gap || (src_q.size() == 0);
        in_dout  = (src_q.size() != 0) ? src_q[0] : '0;
        out_full = ($urandom_range(0, 99) < sink_full_pct);
        #1;
        if (restart_pend) begin
            restart_pend = 0;
            if (!in_empty) check_eq("restart_pop", in_rd_en, 1);
        end
        if (in_rd_en) begin
            if (in_empty) pop_while_empty++;
            else begin
                src_q.delete(0);
                pops++;
            end
        end
        if (out_wr_en) begin
            if (out_full) wr_while_full++;
            else begin
                writes++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) check_eq("extra_byte", out_din, 0);
                else check_eq($sformatf("byte%0d", writes), out_din, exp_q.pop_front());
            end
        end
        if (frame_done) begin
            fd_count++;
            check_eq("done_latency", cyc - last_wr_cyc, 1);
            check_eq("busy_at_done", busy, 0);
`ifdef PACKER_CHECKSUM_EN
            if (sum_q.size() != 0) check_eq("frame_sum", frame_sum, sum_q.pop_front());
`else
            if (sum_q.size() != 0) sum_q.delete(0);
`endif
            restart_pend = 1;
        end
        if (in_frame && !frame_done && busy !== 1'b1) busy_err++;
        if (in_rd_en && !in_empty) in_frame = 1;
        if (frame_done) in_frame = 0;
        if (int'(row_count) > rc_max) rc_max = int'(row_count);
    endtask

    task automatic run_frames(input string name, input int nframes, input bit ramp);
        int k;
        clear_counts();
        for (int f = 0; f < nframes; f++) load_frame(ramp);
        for (k = 0; k < 3000 && fd_count < nframes; k++) step();
        if (fd_count < nframes) check_eq({name, "_timeout"}, 1, 0);
        repeat (3) step();
        check_eq({name, "_bytes"}, writes, nframes * H * ((W * CH + 3) / 4) * 4);
        check_eq({name, "_leftover"}, exp_q.size(), 0);
        check_eq({name, "_done_cnt"}, fd_count, nframes);
        check_eq({name, "_pops"}, pops, nframes * W * H);
        check_eq({name, "_busy_gap"}, busy_err, 0);
        check_eq({name, "_wr_full"}, wr_while_full, 0);
        check_eq({name, "_pop_empty"}, pop_while_empty, 0);
        check_eq({name, "_row_max"}, rc_max, H - 1);
        check_eq({name, "_idle_row"}, row_count, 0);
        check_eq({name, "_idle_busy"}, busy, 0);
        check_eq({name, "_idle_state"}, state_dbg, S_FETCH);
    endtask

    task automatic check_reset_vals(input string name);
        check_eq({name, "_rd_en"}, in_rd_en, 0);
        check_eq({name, "_wr_en"}, out_wr_en, 0);
        check_eq({name, "_din"}, out_din, 0);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_done"}, frame_done, 0);
        check_eq({name, "_row"}, row_count, 0);
        check_eq({name, "_state"}, state_dbg, S_FETCH);
`ifdef PACKER_CHECKSUM_EN
        check_eq({name, "_sum"}, frame_sum, 0);
`endif
    endtask

    task automatic abort_frame();
        int k;
        clear_counts();
        load_frame(1'b1);
        for (k = 0; k < 200 && writes < 7; k++) step();
        check_eq("abort_reached7", writes, 7);
        @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b1;
        out_full = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        src_q.delete();
        exp_q.delete();
        sum_q.delete();
        in_frame = 0;
        restart_pend = 0;
        #1;
        check_reset_vals("abort");
        check_eq("abort_no_done", fd_count, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_empty = 1'b1;
        in_dout  = '0;
        out_full = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;

        sink_full_pct = 0;  src_mode = 0;
        run_frames("ramp", 1, 1'b1);

        sink_full_pct = 50; src_mode = 0;
        run_frames("sinkstall", 1, 1'b1);

        sink_full_pct = 0;  src_mode = 1;
        run_frames("srcgap", 1, 1'b1);

        sink_full_pct = 40; src_mode = 2;
        run_frames("random", 2, 1'b0);

        sink_full_pct = 0;  src_mode = 0;
        abort_frame();
        run_frames("post_abort", 1, 1'b1);

        sink_full_pct = 0;  src_mode = 0;
        run_frames("b2b", 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bmp_pixel_packer.md
Name: bmp_pixel_packer

Overview:
- Sits between the sobel output FIFO and the memory/BMP writer path.
- Pops one GRAYSCALE pixel per source word and emits CHANNELS identical bytes per pixel into a byte-wide sink FIFO.
- Inserts BMP row padding so every row is a multiple of 4 bytes, and counts rows/columns to flag end of frame.
- Generalises gray-to-BGR byte replication (previously testbench-only) to arbitrary width, height, channel count and pixel width, and adds padding and frame tracking.

Parameters:
- IMG_WIDTH, 720, pixels per row (>=1)
- IMG_HEIGHT, 540, rows per frame (>=1)
- IN_DWIDTH, 8, source pixel width; only the upper 8 bits are emitted
- CHANNELS, 3, bytes emitted per pixel (1..4)
- PAD_BYTES, derived as (4 - (IMG_WIDTH*CHANNELS) mod 4) mod 4; localparam, not overridable

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_dout  in  IN_DWIDTH  source FIFO data; first-word-fall-through, valid whenever in_empty=0
- in_empty  in  1  source FIFO empty
- in_rd_en  out  1  source pop
- out_din  out  8  sink FIFO data
- out_full  in  1  sink FIFO full
- out_wr_en  out  1  sink push
- busy  out  1  high from first pop until frame end
- frame_done  out  1  one-cycle pulse after the last byte of a frame
- row_count  out  clog2(IMG_HEIGHT+1)  completed rows in the current frame

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=S_FETCH; pix_reg, chan_cnt, col_cnt, pad_cnt, row_count=0; in_rd_en=0, out_wr_en=0, out_din=0, busy=0, frame_done=0.
- in_rd_en, out_wr_en and out_din are combinational from registered state plus in_empty/out_full. All other outputs are registered.
- S_FETCH:
  - in_rd_en = ~in_empty.
  - On a pop: pix_reg <= in_dout[IN_DWIDTH-1 -: 8], chan_cnt <= 0, busy <= 1, go to S_EMIT.
- S_EMIT:
  - out_wr_en = ~out_full; out_din = pix_reg.
  - On each accepted write, chan_cnt increments.
  - On the write with chan_cnt=CHANNELS-1:
    - If col_cnt<IMG_WIDTH-1: col_cnt++. If ~in_empty, pop the next pixel in the same cycle (in_rd_en=1, stay in S_EMIT, chan_cnt<=0); otherwise go to S_FETCH.
    - If col_cnt=IMG_WIDTH-1: col_cnt<=0. Go to S_PAD if PAD_BYTES>0, else S_ROWEND.
- S_PAD: out_din=8'h00, out_wr_en=~out_full. pad_cnt counts 0..PAD_BYTES-1, then go to S_ROWEND.
- S_ROWEND (1 cycle, no handshake):
  - row_count++.
  - If row_count=IMG_HEIGHT-1: pulse frame_done, row_count<=0, busy<=0.
  - Go to S_FETCH.
- Throughput: one byte per cycle while the sink is not full and the source is not empty. Plus one bubble cycle per row (S_ROWEND) and one per source stall.
- Sink full: hold state and out_din, deassert out_wr_en; no byte is lost or duplicated.
- Source empty in S_FETCH: wait indefinitely with all counters held.
- Never pops a pixel while bytes of the previous pixel remain unwritten.
- Back-to-back frames are supported; the next frame starts in the cycle after the frame_done pulse.
- Reset mid-frame: abandons the frame with no frame_done; counters clear the next cycle.

Optional Feature:
- Macro: PACKER_CHECKSUM_EN.
- With the macro defined:
  - Adds output port frame_sum[15:0]: a registered modulo-2^16 sum of every byte written (pixels and pad) in the current frame.
  - The sum is captured on frame_done and held until the next frame_done or reset.
  - An internal accumulator clears at frame start and on reset.
- Without the macro: the port and all logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package image_pkg:
  - bmp_row_bytes(width, channels) and bmp_pad_bytes(width, channels) constant functions
  - BMP_HEADER_SIZE=54
  - state enum encodings S_FETCH, S_EMIT, S_PAD, S_ROWEND
- Optional sub-module pixel_pos_counter (column/row counters with wrap and last-pixel flags), reusable by the sobel line buffer.
- Everything else stays flat.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=2, CHANNELS=3, pixels 1..10, sink never full → byte stream:
  - row 0: 01 01 01 02 02 02 … 05 05 05 00
  - row 1: 06 06 06 … 0A 0A 0A 00
  - 32 bytes total; frame_done pulses once, one cycle after the last write.
- Default 720x540x3 with a ramp pattern → 1166400 bytes, zero pad bytes, row_count wraps to 0, and exactly one frame_done.
- Sink out_full toggled randomly at 50% on the 5x2 config → byte sequence identical to the unstalled run; no write while full.
- Source empty inserted every other cycle → no extra pops, the emitted sequence is unchanged, and busy stays high across stalls.
- Reset asserted after the 7th byte of the 5x2 frame, then a full frame sent → outputs match the reset values the next cycle, the following frame is byte-exact, and no spurious frame_done occurs.
- PACKER_CHECKSUM_EN, 5x2 pixels 1..10 → frame_sum = 3*55 = 16'h00A5, latched on frame_done.
